pulse_sync_rx: RTL and testbench



---
 rtl/pulse_sync_pkg.sv | 22 ++
 rtl/pulse_sync_rx_fifo.sv | 63 ++++++
 rtl/pulse_sync_rx.sv | 119 +++++++++++
 tb/tb_pulse_sync_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sync_pkg
// Description : Shared types and default widths for the pulse_sync_rx slice.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_sync_pkg;

    // Default data word width, matching the upstream synchronizer.
    localparam int C_N  = 8;
    // Default width of the saturating drop counter.
    localparam int C_CW = 8;

    // Capture FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage : pulse_sync_pkg
`default_nettype wire

// File: rtl/pulse_sync_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO. Pointers carry an
//               extra wrap bit so full and empty are distinguishable.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [N-1:0]             i_din,
    output logic [N-1:0]             o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [N-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_pop;
    logic         w_do_push;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;

    // A pop frees the head slot this edge, so a push may land even when full.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Head word is read straight from storage (fall-through).
    assign o_dout = r_mem[r_rd_ptr[AW-1:0]];

    // Storage and pointer update; reset clears contents so the head reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_din;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/pulse_sync_rx.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sync_rx
// Description : Destination-domain strobe consumer. Captures one word per
//               strobe assertion into a FIFO, presents it on a valid/ready
//               stream and returns a 4-phase ack level. Drops on a full FIFO
//               are flagged by a sticky overflow bit and a saturating count.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_sync_rx
    import pulse_sync_pkg::*;
#(
    parameter int N     = C_N,
    parameter int DEPTH = 4,
    parameter int CW    = C_CW
) (
    input  logic                     clkB,
    input  logic                     rst,
    input  logic                     enaB,
    input  logic                     stb_in,
    input  logic [N-1:0]             data_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [N-1:0]             m_data,
    output logic                     ack,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [CW-1:0]            drop_cnt
);

    state_t        r_state;
    logic          r_ack;
    logic          r_overflow;
    logic [CW-1:0] r_drop_cnt;

    logic          w_push_req;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;

    // The capture happens in CAPT, one edge after the strobe is seen, because
    // the upstream data register updates on the same edge as the strobe.
    assign w_push_req = enaB && (r_state == CAPT);
    assign w_pop      = m_valid && m_ready;
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign m_valid  = !w_empty;
    assign ack      = r_ack;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clkB),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_din   (data_in),
        .o_dout  (m_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    // Capture FSM with registered ack; frozen while enaB is low.
    always_ff @(posedge clkB) begin
        if (rst) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else if (enaB) begin
            case (r_state)
                IDLE: begin
                    if (stb_in) begin
                        r_state <= CAPT;
                    end
                end
                CAPT: begin
                    // Ack is raised even on a drop so the source never stalls.
                    r_state <= HOLD;
                    r_ack   <= 1'b1;
                end
                HOLD: begin
                    if (!stb_in) begin
                        r_state <= IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow and saturating drop count; a same-cycle drop beats clear.
    always_ff @(posedge clkB) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_ovf) begin
                r_drop_cnt <= {{(CW-1){1'b0}}, 1'b1};
            end else if (r_drop_cnt != {CW{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

endmodule : pulse_sync_rx
`default_nettype wire

// File: tb/tb_pulse_sync_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_sync_rx
// Description : Directed self-checking bench for pulse_sync_rx with a
//               scoreboard queue of expected output words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_sync_rx;
    import pulse_sync_pkg::*;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clkB = 1'b0;
    logic          rst = 1'b1;
    logic          enaB = 1'b1;
    logic          stb_in = 1'b0;
    logic [N-1:0]  data_in = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [N-1:0]  m_data;
    logic          ack;
    logic [LW-1:0] level;
    logic          overflow;
    logic          clr_ovf = 1'b0;
    logic [CW-1:0] drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [N-1:0] sb [$];

    pulse_sync_rx #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
        .clkB     (clkB),
        .rst      (rst),
        .enaB     (enaB),
        .stb_in   (stb_in),
        .data_in  (data_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .ack      (ack),
        .level    (level),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .drop_cnt (drop_cnt)
    );

    always #5 clkB = ~clkB;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clkB);
        #1;
    endtask

    // Full strobe handshake: high until captured and acked, then low.
    task automatic send_word(input logic [N-1:0] d);
        stb_in  = 1'b1;
        data_in = d;
        tick(2);
        chk("send_ack_hi", 32'(ack), 32'd1);
        stb_in = 1'b0;
        tick(1);
        chk("send_ack_lo", 32'(ack), 32'd0);
    endtask

    // Scoreboard: every accepted handshake on the stream must match the queue.
    always @(negedge clkB) begin
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL sb_unexpected: observed %0h expected none", m_data);
            end else begin
                chk("sb_data", 32'(m_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        // Reset state
        tick(2);
        rst = 1'b0;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));

        // Basic capture latency and ack phases
        stb_in = 1'b1; data_in = 8'hA5; sb.push_back(8'hA5);
        tick(1);
        chk("t1_capt", 32'(dut.r_state), 32'(CAPT));
        chk("t1_valid0", 32'(m_valid), 32'd0);
        tick(1);
        chk("t1_valid1", 32'(m_valid), 32'd1);
        chk("t1_data", 32'(m_data), 32'hA5);
        chk("t1_ack1", 32'(ack), 32'd1);
        stb_in = 1'b0;
        tick(1);
        chk("t1_ack0", 32'(ack), 32'd0);
        chk("t1_idle", 32'(dut.r_state), 32'(IDLE));
        m_ready = 1'b1; tick(1); m_ready = 1'b0;
        chk("t1_drain", 32'(level), 32'd0);

        // Long strobe yields a single word
        stb_in = 1'b1; data_in = 8'h11; sb.push_back(8'h11);
        tick(2);
        data_in = 8'h22;
        tick(18);
        chk("t2_level", 32'(level), 32'd1);
        chk("t2_data", 32'(m_data), 32'h11);
        chk("t2_ack", 32'(ack), 32'd1);
        stb_in = 1'b0;
        tick(2);
        chk("t2_level_after", 32'(level), 32'd1);
        m_ready = 1'b1; tick(1); m_ready = 1'b0;
        chk("t2_drain", 32'(level), 32'd0);

        // Overflow on 5th word, then clear
        for (int i = 1; i <= 5; i++) begin
            if (i <= DEPTH) sb.push_back(8'(i));
            send_word(8'(i));
        end
        chk("t3_level", 32'(level), 32'd4);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_drop", 32'(drop_cnt), 32'd1);
        chk("t3_head", 32'(m_data), 32'h01);
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
        chk("t3_clr_ovf", 32'(overflow), 32'd0);
        chk("t3_clr_drop", 32'(drop_cnt), 32'd0);
        // Drop coinciding with clear: drop wins
        stb_in = 1'b1; data_in = 8'h06;
        tick(1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("t3_race_ovf", 32'(overflow), 32'd1);
        chk("t3_race_drop", 32'(drop_cnt), 32'd1);
        stb_in = 1'b0;
        tick(1);
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
        chk("t3_clr2", 32'(overflow), 32'd0);
        m_ready = 1'b1; tick(4); m_ready = 1'b0;
        chk("t3_drain", 32'(level), 32'd0);

        // Full with simultaneous pop: push accepted
        for (int i = 1; i <= 4; i++) begin
            sb.push_back(8'(i));
            send_word(8'(i));
        end
        stb_in = 1'b1; data_in = 8'h05; sb.push_back(8'h05);
        tick(1);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        chk("t4_level", 32'(level), 32'd4);
        chk("t4_ovf", 32'(overflow), 32'd0);
        chk("t4_drop", 32'(drop_cnt), 32'd0);
        stb_in = 1'b0;
        tick(1);
        m_ready = 1'b1; tick(4); m_ready = 1'b0;
        chk("t4_drain", 32'(level), 32'd0);

        // enaB low while in CAPT freezes the capture
        stb_in = 1'b1; data_in = 8'h77;
        tick(1);
        enaB = 1'b0;
        tick(3);
        chk("t5_state", 32'(dut.r_state), 32'(CAPT));
        chk("t5_level0", 32'(level), 32'd0);
        chk("t5_ack0", 32'(ack), 32'd0);
        enaB = 1'b1; sb.push_back(8'h77);
        tick(1);
        chk("t5_level1", 32'(level), 32'd1);
        chk("t5_ack1", 32'(ack), 32'd1);
        stb_in = 1'b0;
        tick(3);
        chk("t5_single", 32'(level), 32'd1);
        m_ready = 1'b1; tick(1); m_ready = 1'b0;

        // Reset while in HOLD with two words buffered
        sb.push_back(8'h33);
        send_word(8'h33);
        stb_in = 1'b1; data_in = 8'h44;
        tick(2);
        chk("t6_pre_level", 32'(level), 32'd2);
        chk("t6_pre_ack", 32'(ack), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("t6_ack", 32'(ack), 32'd0);
        chk("t6_valid", 32'(m_valid), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_state", 32'(dut.r_state), 32'(IDLE));
        sb.delete();
        rst = 1'b0; data_in = 8'h55; sb.push_back(8'h55);
        tick(2);
        chk("t6_recapt_level", 32'(level), 32'd1);
        chk("t6_recapt_data", 32'(m_data), 32'h55);
        tick(3);
        chk("t6_single", 32'(level), 32'd1);
        stb_in = 1'b0;
        tick(1);
        m_ready = 1'b1; tick(1); m_ready = 1'b0;
        chk("t6_drain", 32'(level), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pulse_sync_rx
`default_nettype wire
